// File: rtl/axis_pattern_generator.sv
// AXI4-Stream video test-pattern source: gradient, colour bars, checkerboard or solid
// frames of H_RES x V_RES pixels behind a single registered output stage.
module axis_pattern_generator #(
    parameter int DATA_WIDTH   = 16,
    parameter int H_RES        = 1024,
    parameter int V_RES        = 768,
    parameter int CHECKER_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable_i,
    input  logic [1:0]            mode_i,
    input  logic [DATA_WIDTH-1:0] solid_color_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [15:0]           frame_cnt_o,
    output logic                  busy_o
);
    localparam int XW      = $clog2(H_RES);
    localparam int YW      = $clog2(V_RES);
    localparam int BAR_LEN = H_RES / 8;
    localparam int BW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                r_state, w_state_nx;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [BW-1:0]         r_bcnt;
    logic [2:0]            r_bar;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_solid;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid, r_tlast, r_tuser;
    logic                  r_olast;
    logic [15:0]           r_frame_cnt;

    logic w_hs, w_x_last, w_y_last, w_gen_last, w_bcnt_last;
    logic w_fin, w_stop, w_load, w_latch;
    logic w_cx, w_cy, w_ph;
    logic [7:0] w_g, w_r, w_gc, w_b;
    logic [DATA_WIDTH-1:0] w_rgb_pk, w_pix;

    // x/y/bar address the pixel about to enter the output register, one ahead of the bus
    assign w_hs        = r_tvalid & m_axis_tready;
    assign w_x_last    = (r_x == XW'(H_RES - 1));
    assign w_y_last    = (r_y == YW'(V_RES - 1));
    assign w_gen_last  = w_x_last & w_y_last;
    assign w_bcnt_last = (r_bcnt == BW'(BAR_LEN - 1));
    assign w_fin       = w_hs & r_olast;
    assign w_stop      = w_fin & ~enable_i;
    assign w_load      = (r_state == S_STREAM) & (~r_tvalid | w_hs) & ~w_stop;
    assign w_latch     = ((r_state == S_IDLE) & enable_i) | (w_load & w_gen_last);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (enable_i) w_state_nx = S_STREAM;
            S_STREAM: if (w_stop)   w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    // When the bus holds a frame's final pixel, the generator is already on the next frame
    assign w_g  = 8'(r_x) + 8'(r_y) + r_frame_cnt[7:0] + {7'd0, r_olast};
    assign w_ph = r_frame_cnt[0] ^ r_olast;

    if (CHECKER_LOG2 < XW) begin : g_cx
        assign w_cx = r_x[CHECKER_LOG2];
    end else begin : g_cx0
        assign w_cx = 1'b0;
    end
    if (CHECKER_LOG2 < YW) begin : g_cy
        assign w_cy = r_y[CHECKER_LOG2];
    end else begin : g_cy0
        assign w_cy = 1'b0;
    end

    always_comb begin
        w_r  = 8'h00;
        w_gc = 8'h00;
        w_b  = 8'h00;
        case (r_mode)
            2'd0: begin w_r = w_g; w_gc = w_g; w_b = w_g; end
            2'd1: begin
                w_r  = {8{~r_bar[1]}};
                w_gc = {8{~r_bar[2]}};
                w_b  = {8{~r_bar[0]}};
            end
            2'd2: {w_r, w_gc, w_b} = {24{w_cx ^ w_cy ^ w_ph}};
            default: ;
        endcase
    end

    if (DATA_WIDTH == 16) begin : g_565
        logic w_unused_lsb;
        assign w_rgb_pk     = {w_r[7:3], w_gc[7:2], w_b[7:3]};
        assign w_unused_lsb = ^{w_r[2:0], w_gc[1:0], w_b[2:0]};
    end else if (DATA_WIDTH == 24) begin : g_888
        assign w_rgb_pk = {w_r, w_gc, w_b};
    end else begin : g_bad_width
        $error("axis_pattern_generator: DATA_WIDTH must be 16 or 24");
    end

    if ((H_RES % 8 != 0) || (H_RES < 8) || (V_RES < 2)) begin : g_bad_res
        $error("axis_pattern_generator: H_RES must be a multiple of 8 and V_RES >= 2");
    end

    assign w_pix = (r_mode == 2'd3) ? r_solid : w_rgb_pk;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_x    <= '0;
            r_y    <= '0;
            r_bcnt <= '0;
            r_bar  <= '0;
        end else if (w_load) begin
            r_x <= w_x_last ? '0 : r_x + XW'(1);
            if (w_x_last) r_y <= w_y_last ? '0 : r_y + YW'(1);
            if (w_x_last || w_bcnt_last) begin
                r_bcnt <= '0;
                r_bar  <= w_x_last ? 3'd0 : r_bar + 3'd1;
            end else begin
                r_bcnt <= r_bcnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mode  <= '0;
            r_solid <= '0;
        end else if (w_latch) begin
            r_mode  <= mode_i;
            r_solid <= solid_color_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
            r_olast  <= 1'b0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_pix;
            r_tlast  <= w_x_last;
            r_tuser  <= (r_x == '0) && (r_y == '0);
            r_olast  <= w_gen_last;
        end else if (w_hs) begin
            r_tvalid <= 1'b0;
            r_olast  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)      r_frame_cnt <= '0;
        else if (w_fin) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;
    assign frame_cnt_o   = r_frame_cnt;
    assign busy_o        = (r_state == S_STREAM);
endmodule

// File: tb/tb_axis_pattern_generator.sv
// Scoreboard bench for axis_pattern_generator: 8x4 RGB888 frames, expected beats
// queued as frames are requested and popped on every handshake.
module tb_axis_pattern_generator;
  localparam int DW = 24;
  localparam int HR = 8;
  localparam int VR = 4;
  localparam int CL = 1;

  logic          clk = 1'b0;
  logic          rstn, enable_i, m_axis_tready;
  logic [1:0]    mode_i;
  logic [DW-1:0] solid_color_i, m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy_o;
  logic [15:0]   frame_cnt_o;

  axis_pattern_generator #(.DATA_WIDTH(DW), .H_RES(HR), .V_RES(VR), .CHECKER_LOG2(CL)) dut (
    .clk(clk), .rstn(rstn), .enable_i(enable_i), .mode_i(mode_i),
    .solid_color_i(solid_color_i), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .frame_cnt_o(frame_cnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic          u;
  } beat_t;

  beat_t       sb[$];
  int          n_chk = 0, n_fail = 0;
  int          n_beats = 0, run = 0, cyc = 0, last_hs = -10;
  bit          rnd_rdy = 1'b0, stall_q = 1'b0;
  logic [26:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_pix(input int mode, input logic [DW-1:0] solid,
                                            input int x, input int y, input int fc);
    logic [7:0] g;
    int bar;
    case (mode)
      0: begin
        g = 8'((x + y + fc) % 256);
        return {g, g, g};
      end
      1: begin
        bar = x / (HR / 8);
        case (bar)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2: return ((((x >> CL) ^ (y >> CL) ^ fc) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return solid;
    endcase
  endfunction

  task automatic push_frame(input int mode, input logic [DW-1:0] solid, input int fc);
    beat_t b;
    for (int y = 0; y < VR; y++)
      for (int x = 0; x < HR; x++) begin
        b.d = exp_pix(mode, solid, x, y, fc);
        b.l = (x == HR - 1);
        b.u = (x == 0) && (y == 0);
        sb.push_back(b);
      end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick(1);
      n++;
    end
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  task automatic wait_beats(input string tag, input int target);
    int n = 0;
    while (n_beats < target && n < 400) begin
      tick(1);
      n++;
    end
    chk({tag, "_wait"}, n_beats, target);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tdata"},  m_axis_tdata, 0);
    chk({tag, "_tlast"},  m_axis_tlast, 0);
    chk({tag, "_tuser"},  m_axis_tuser, 0);
    chk({tag, "_busy"},   busy_o, 0);
    chk({tag, "_fcnt"},   frame_cnt_o, 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) m_axis_tready = 1'($urandom_range(0, 1));
  end

  // Handshake decided at the negedge: tready only changes just after posedges
  always @(negedge clk) begin : mon
    beat_t b;
    if (stall_q) chk("hold", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, held);
    if (m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        chk("extra_beat", sb.size(), 1);
      end else begin
        b = sb.pop_front();
        chk("tdata", m_axis_tdata, b.d);
        chk("tlast", m_axis_tlast, b.l);
        chk("tuser", m_axis_tuser, b.u);
      end
      n_beats <= n_beats + 1;
      run     <= (cyc == last_hs + 1) ? run + 1 : 1;
      last_hs <= cyc;
    end
    stall_q <= m_axis_tvalid && !m_axis_tready;
    held    <= {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rstn = 1'b0; enable_i = 1'b0; m_axis_tready = 1'b0; mode_i = 2'd0; solid_color_i = '0;
    tick(3);
    chk_reset("rst");
    rstn = 1'b1;
    tick(2);
    chk("idle_busy", busy_o, 0);
    chk("idle_tvalid", m_axis_tvalid, 0);

    // gradient, random backpressure
    mode_i = 2'd0; enable_i = 1'b1; rnd_rdy = 1'b1;
    push_frame(0, '0, 0);
    tick(2);
    enable_i = 1'b0;
    drain("grad");
    rnd_rdy = 1'b0; m_axis_tready = 1'b1;
    chk("grad_fcnt", frame_cnt_o, 1);
    chk("grad_tvalid_after", m_axis_tvalid, 0);
    chk("grad_busy_after", busy_o, 0);

    // colour bars, ready held high: 32 back-to-back beats
    mode_i = 2'd1; enable_i = 1'b1;
    push_frame(1, '0, 1);
    tick(2);
    enable_i = 1'b0;
    drain("bars");
    chk("bars_no_bubble", run, 32);
    chk("bars_fcnt", frame_cnt_o, 2);
    chk("bars_tvalid_after", m_axis_tvalid, 0);

    // mode change mid-frame only takes effect at the next frame
    mode_i = 2'd2; enable_i = 1'b1;
    push_frame(2, '0, 2);
    push_frame(3, 24'h12A5C3, 3);
    tick(10);
    mode_i = 2'd3; solid_color_i = 24'h12A5C3;
    tick(35);
    solid_color_i = 24'h5A0F77; mode_i = 2'd0; enable_i = 1'b0;
    drain("mode");
    chk("mode_fcnt", frame_cnt_o, 4);

    // enable dropped at pixel (2,1): frame still completes
    mode_i = 2'd2; enable_i = 1'b1; rnd_rdy = 1'b1;
    base = n_beats;
    push_frame(2, '0, 4);
    wait_beats("en", base + 10);
    enable_i = 1'b0;
    drain("en");
    rnd_rdy = 1'b0; m_axis_tready = 1'b1;
    chk("en_tvalid_after", m_axis_tvalid, 0);
    chk("en_busy_after", busy_o, 0);
    chk("en_fcnt", frame_cnt_o, 5);

    // reset while pixel (5,2) is on the bus
    mode_i = 2'd0; enable_i = 1'b1;
    base = n_beats;
    push_frame(0, '0, 5);
    wait_beats("rst2", base + 21);
    rstn = 1'b0;
    tick(1);
    chk_reset("rst2");
    sb.delete();
    rstn = 1'b1;
    push_frame(0, '0, 0);
    tick(2);
    enable_i = 1'b0;
    drain("rst2");
    chk("rst2_fcnt", frame_cnt_o, 1);

    // frame counter wrap; checker phase flips between frames
    force dut.r_frame_cnt = 16'hFFFF;
    tick(1);
    release dut.r_frame_cnt;
    tick(1);
    chk("wrap_pre", frame_cnt_o, 16'hFFFF);
    mode_i = 2'd2; enable_i = 1'b1;
    push_frame(2, '0, 'hFFFF);
    push_frame(2, '0, 0);
    tick(40);
    chk("wrap_zero", frame_cnt_o, 0);
    enable_i = 1'b0;
    drain("wrap");
    chk("wrap_fcnt", frame_cnt_o, 1);
    chk("wrap_tvalid_after", m_axis_tvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_pattern_generator.md
AXIS_PATTERN_GENERATOR -- requirements
Module: axis_pattern_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 16, pixel format: 16 = RGB565 {R5,G6,B5}, 24 = RGB888 {R8,G8,B8}; any other value SHALL fail elaboration.
REQ-002 Parameter H_RES, default 1024, active pixels per line; SHALL be a multiple of 8 and >= 8.
REQ-003 Parameter V_RES, default 768, lines per frame; SHALL be >= 2.
REQ-004 Parameter CHECKER_LOG2, default 5, log2 of checker square edge in pixels.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 enable_i  input  1  run request; sampled only at frame boundaries.
REQ-008 mode_i  input  2  pattern select: 0 gradient, 1 colour bars, 2 checkerboard, 3 solid.
REQ-009 solid_color_i  input  DATA_WIDTH  pixel value for mode 3.
REQ-010 m_axis_tdata  output  DATA_WIDTH  pixel data.
REQ-011 m_axis_tvalid  output  1  AXI4-Stream valid.
REQ-012 m_axis_tready  input  1  AXI4-Stream ready.
REQ-013 m_axis_tlast  output  1  high on the last pixel of each line (x = H_RES-1).
REQ-014 m_axis_tuser  output  1  start of frame; high only on pixel (0,0).
REQ-015 frame_cnt_o  output  16  count of completed frames.
REQ-016 busy_o  output  1  high while in state STREAM.

Function
REQ-017 FSM states: IDLE, STREAM. IDLE -> STREAM when enable_i = 1; STREAM -> IDLE on handshake of pixel (H_RES-1, V_RES-1) when enable_i = 0; otherwise STREAM continues with the next frame.
REQ-018 The transition into STREAM and every frame start SHALL latch mode_i and solid_color_i; both are ignored mid-frame.
REQ-019 Counters x (0..H_RES-1) and y (0..V_RES-1) advance only on handshake (tvalid & tready): x wraps to 0 after H_RES-1 and increments y; y wraps to 0 after V_RES-1.
REQ-020 Output is a registered stage: tvalid asserts the cycle after STREAM is entered; while tvalid = 1 and tready = 0, tdata/tlast/tuser SHALL stay stable.
REQ-021 With tready held high, one pixel per clock with zero bubbles, including across line and frame boundaries.
REQ-022 tvalid deasserts the cycle after the final-pixel handshake when returning to IDLE; no partial frames are emitted except through reset.
REQ-023 Gradient: s = x + y + frame_cnt_o[7:0] in a width that cannot overflow, then truncated modulo 256 to 8-bit g; RGB888 = {g,g,g}, RGB565 = {g[7:3],g[7:2],g[7:3]}.
REQ-024 Colour bars: bar index 0..7 increments every H_RES/8 pixels via a counter (no divider); colours white, yellow, cyan, green, magenta, red, blue, black with full channel value 8'hFF, else 8'h00, packed as REQ-023.
REQ-025 Checkerboard: pixel is white when (x>>CHECKER_LOG2) xor (y>>CHECKER_LOG2) xor frame_cnt_o[0] has bit 0 = 1, else black.
REQ-026 Solid: tdata = latched solid_color_i.
REQ-027 frame_cnt_o increments by 1 on the final-pixel handshake of each frame and wraps 16'hFFFF -> 0.
REQ-028 Pattern computation SHALL depend only on the registered x, y, latched mode and frame_cnt_o; logic depth from them to tdata is at most one add plus one mux.

Reset
REQ-029 rstn = 0 at a clock edge forces state IDLE, x = y = 0, frame_cnt_o = 0, tvalid = 0, tdata = 0, tlast = 0, tuser = 0, busy_o = 0, latched mode = 0, latched solid = 0.
REQ-030 Reset mid-frame SHALL abandon the frame immediately; after release, with enable_i = 1, the first pixel is (0,0) with tuser = 1.

Verification
REQ-031 H_RES=8, V_RES=4, mode 1, tready=1, enable_i=1 -> 32 consecutive beats; tuser only on beat 0; tlast on beats 7,15,23,31; tdata cycles white, yellow, ... black per line; frame_cnt_o = 1 after beat 31.
REQ-032 Random tready (50 %), mode 0, DATA_WIDTH=24 -> tdata/tlast/tuser never change while tvalid & !tready; frame 0 pixel (3,2) = 24'h050505.
REQ-033 mode_i changed 2 -> 3 mid-frame -> current frame remains checkerboard; next frame starts solid with value sampled at its first pixel.
REQ-034 enable_i dropped at pixel (2,1) -> frame completes all 32 beats, tvalid = 0 the cycle after, busy_o = 0, frame_cnt_o increments once.
REQ-035 rstn pulsed low at pixel (5,2) -> all outputs at reset values next cycle; after release, first beat has tuser = 1, x = y = 0, frame_cnt_o = 0.
REQ-036 Force frame_cnt_o to 16'hFFFF, complete one frame -> wraps to 0; checkerboard phase inverts between consecutive frames.
